// File: rtl/i2c_cmd_arbiter_if.sv
// Bus between the two command requesters, the arbiter and the shared
// UART2I2C command converter.
//
// Handshake semantics:
//   x_req is a level held by the requester until it sees the one-cycle x_gnt
//   pulse. x_gnt means the command fields were latched. Exactly one of
//   x_done / x_err then pulses for one cycle per grant. cmdvalid is a
//   one-cycle strobe to the converter with num_cmd/address/cmd_data stable
//   from that cycle until the next grant. The converter signals completion
//   with a rising edge on eeprom_rd_done / eeprom_wr_done. A held level is
//   never treated as a new completion.
interface i2c_cmd_arbiter_if;
  logic         a_req;
  logic [7:0]   a_num_cmd;
  logic [15:0]  a_address;
  logic [127:0] a_wrdata;
  logic         a_gnt;
  logic         a_done;
  logic         a_err;

  logic         b_req;
  logic [7:0]   b_num_cmd;
  logic [15:0]  b_address;
  logic [127:0] b_wrdata;
  logic         b_gnt;
  logic         b_done;
  logic         b_err;

  logic [127:0] rsp_rddata;

  logic         cmdvalid;
  logic [7:0]   num_cmd;
  logic [15:0]  address;
  logic [127:0] cmd_data;
  logic         eeprom_rd_done;
  logic         eeprom_wr_done;
  logic [127:0] eeprom_rddata;

  // Requesters and converter side
  modport master (
    output a_req, a_num_cmd, a_address, a_wrdata,
    output b_req, b_num_cmd, b_address, b_wrdata,
    output eeprom_rd_done, eeprom_wr_done, eeprom_rddata,
    input  a_gnt, a_done, a_err, b_gnt, b_done, b_err,
    input  rsp_rddata, cmdvalid, num_cmd, address, cmd_data
  );

  // Arbiter side
  modport slave (
    input  a_req, a_num_cmd, a_address, a_wrdata,
    input  b_req, b_num_cmd, b_address, b_wrdata,
    input  eeprom_rd_done, eeprom_wr_done, eeprom_rddata,
    output a_gnt, a_done, a_err, b_gnt, b_done, b_err,
    output rsp_rddata, cmdvalid, num_cmd, address, cmd_data
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one EEPROM command converter between the UART
// command parser (A) and the init/poll engine (B). One command is in flight
// at a time. Completion is a rising edge of the expected done input, bounded
// by a timeout.
module i2c_cmd_arbiter #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic               clk50M,
  input  logic               rst_n,
  i2c_cmd_arbiter_if.slave   bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t       state_q;
  logic         last_b_q;     // 1: B was granted last, so A wins the next tie
  logic         sel_b_q;      // requester owning the command in flight
  logic         rw_q;         // 1: read command
  logic [23:0]  timer_q;
  logic         prev_rd_q;
  logic         prev_wr_q;
  logic         a_gnt_q, a_done_q, a_err_q;
  logic         b_gnt_q, b_done_q, b_err_q;
  logic         cmdvalid_q;
  logic [7:0]   num_cmd_q;
  logic [15:0]  address_q;
  logic [127:0] cmd_data_q;
  logic [127:0] rsp_q;

  logic         any_req_d;
  logic         pick_b_d;
  logic [7:0]   sel_num_d;
  logic [15:0]  sel_addr_d;
  logic [127:0] sel_data_d;
  logic         len_ok_d;
  logic         rd_rise_d;
  logic         wr_rise_d;
  logic         exp_rise_d;
  logic         timeout_d;

  // Arbitration choice, length check and completion-edge decode
  always_comb begin
    any_req_d  = bus.a_req | bus.b_req;
    pick_b_d   = 1'b0;
    if (bus.a_req && bus.b_req) pick_b_d = ~last_b_q;
    else                        pick_b_d = bus.b_req;
    sel_num_d  = pick_b_d ? bus.b_num_cmd : bus.a_num_cmd;
    sel_addr_d = pick_b_d ? bus.b_address : bus.a_address;
    sel_data_d = pick_b_d ? bus.b_wrdata  : bus.a_wrdata;
    len_ok_d   = (sel_num_d[6:0] != 7'd0) && (sel_num_d[6:0] <= 7'd16);
    rd_rise_d  = bus.eeprom_rd_done & ~prev_rd_q;
    wr_rise_d  = bus.eeprom_wr_done & ~prev_wr_q;
    exp_rise_d = rw_q ? rd_rise_d : wr_rise_d;
    timeout_d  = (timer_q == TIMEOUT_CYC - 24'd1);
  end

  // Done-input history, sampled every cycle regardless of state
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      prev_rd_q <= 1'b0;
      prev_wr_q <= 1'b0;
    end else begin
      prev_rd_q <= bus.eeprom_rd_done;
      prev_wr_q <= bus.eeprom_wr_done;
    end
  end

  // Command FSM with registered strobes, pulses and latched command fields
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_b_q   <= 1'b1;
      sel_b_q    <= 1'b0;
      rw_q       <= 1'b0;
      timer_q    <= 24'd0;
      a_gnt_q    <= 1'b0;
      a_done_q   <= 1'b0;
      a_err_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      b_done_q   <= 1'b0;
      b_err_q    <= 1'b0;
      cmdvalid_q <= 1'b0;
      num_cmd_q  <= 8'd0;
      address_q  <= 16'd0;
      cmd_data_q <= 128'd0;
      rsp_q      <= 128'd0;
    end else begin
      a_gnt_q    <= 1'b0;
      a_done_q   <= 1'b0;
      a_err_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      b_done_q   <= 1'b0;
      b_err_q    <= 1'b0;
      cmdvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            sel_b_q    <= pick_b_d;
            rw_q       <= sel_num_d[7];
            num_cmd_q  <= sel_num_d;
            address_q  <= sel_addr_d;
            cmd_data_q <= sel_data_d;
            a_gnt_q    <= ~pick_b_d;
            b_gnt_q    <= pick_b_d;
            if (len_ok_d) begin
              state_q <= S_ISSUE;
            end else begin
              // Bad length: reject without touching the converter
              a_err_q <= ~pick_b_d;
              b_err_q <= pick_b_d;
              state_q <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          cmdvalid_q <= 1'b1;
          timer_q    <= 24'd0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + 24'd1;
          // Completion takes priority over a coincident timeout
          if (exp_rise_d) begin
            if (rw_q) rsp_q <= bus.eeprom_rddata;
            a_done_q <= ~sel_b_q;
            b_done_q <= sel_b_q;
            state_q  <= S_RESP;
          end else if (timeout_d) begin
            a_err_q <= ~sel_b_q;
            b_err_q <= sel_b_q;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          last_b_q <= sel_b_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.a_gnt      = a_gnt_q;
  assign bus.a_done     = a_done_q;
  assign bus.a_err      = a_err_q;
  assign bus.b_gnt      = b_gnt_q;
  assign bus.b_done     = b_done_q;
  assign bus.b_err      = b_err_q;
  assign bus.cmdvalid   = cmdvalid_q;
  assign bus.num_cmd    = num_cmd_q;
  assign bus.address    = address_q;
  assign bus.cmd_data   = cmd_data_q;
  assign bus.rsp_rddata = rsp_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
Shares the single UART2I2C command converter (multi-byte EEPROM read/write sequencer) between two command requesters. Requester A is the UART command parser; requester B is the on-board init/poll engine. The block arbitrates round-robin and issues one command to the converter at a time. It watches for completion or timeout and returns done/err pulses plus read data to the granted requester.

Parameters:
TIMEOUT_CYC, 24'd5_000_000, cycles allowed from cmdvalid to completion (100 ms at 50 MHz); must be >= 2.

Ports:
clk50M  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
a_req  in  1  requester A command request, level; hold until a_gnt
a_num_cmd  in  8  bit7 = 1 read / 0 write; bits[6:0] = byte count
a_address  in  16  EEPROM start address
a_wrdata  in  128  write bytes, first byte in [127:120]
a_gnt  out  1  one-cycle pulse: A's command latched
a_done  out  1  one-cycle pulse: A's command completed
a_err  out  1  one-cycle pulse: A's command rejected or timed out
b_req, b_num_cmd, b_address, b_wrdata, b_gnt, b_done, b_err  same as A, for requester B
rsp_rddata  out  128  read data of the last successful read, first byte in [127:120]
cmdvalid  out  1  one-cycle command strobe to converter
num_cmd  out  8  latched command num_cmd
address  out  16  latched command address
cmd_data  out  128  latched command write data
eeprom_rd_done  in  1  converter read completion
eeprom_wr_done  in  1  converter write completion
eeprom_rddata  in  128  converter read data, valid when eeprom_rd_done rises

Behaviour:
- Reset: state IDLE. All outputs 0, including rsp_rddata, num_cmd, address and cmd_data. last_grant = B, so A wins the first tie. Timer = 0. Edge registers = 0.
- Reset mid-command aborts the command with no done/err pulse. The requester must re-request.
- Done edge detection: prev_rd and prev_wr are registered every cycle in all states. Completion is a rising edge (input 1, prev 0). Level-high done inputs never re-trigger.
- IDLE:
  - Only A requesting -> grant A. Only B requesting -> grant B. Both requesting -> grant the one that is not last_grant.
  - On grant: latch that requester's num_cmd/address/wrdata into the output registers, store rw = num_cmd[7], and pulse x_gnt the next cycle.
  - Length check: len = num_cmd[6:0]. If len == 0 or len > 16, go to RESP with err and issue nothing. Otherwise go to ISSUE.
  - No request -> stay IDLE.
- ISSUE: cmdvalid = 1 for exactly one cycle, timer cleared, go to WAIT.
- WAIT: timer increments each cycle.
  - Rising edge of the expected done (rd if rw = 1, wr if rw = 0) -> go to RESP with ok. On a read, rsp_rddata <= eeprom_rddata in the same cycle.
  - Rising edge of the non-expected done is ignored.
  - timer == TIMEOUT_CYC-1 with no expected edge -> go to RESP with err. Completion wins if both occur in the same cycle.
- RESP: pulse x_done (ok) or x_err (err) for one cycle to the granted requester only. last_grant <= granted. Go to IDLE.
- Cycle budget: req seen in IDLE at cycle N -> gnt at N+1, cmdvalid at N+2. Done edge at cycle M -> x_done at M+1.
- The next arbitration can occur the cycle after RESP. A requester still holding req after gnt is treated as a new command.
- rsp_rddata holds its value until the next successful read. Writes, errors and timeouts leave it unchanged.
- Requests arriving outside IDLE are not lost while held; they are arbitrated at the next IDLE.
- num_cmd, address and cmd_data hold their values until the next grant.

Test Plan:
1. A write: a_num_cmd=8'h04, a_address=16'h0010, a_wrdata[127:96]=32'hDEADBEEF -> a_gnt, then 1-cycle cmdvalid with num_cmd=8'h04 and address=16'h0010. Pulse eeprom_wr_done -> a_done one cycle later; b_* and a_err stay 0.
2. B read: b_num_cmd=8'h82, respond eeprom_rddata[127:112]=16'hA55A with an eeprom_rd_done rising edge -> b_done pulse; rsp_rddata[127:112]=16'hA55A.
3. A and B requesting in the same cycle repeatedly -> grants alternate A, B, A, B. Exactly one cmdvalid per grant; no second cmdvalid before the prior done/err.
4. Invalid lengths a_num_cmd=8'h00 and 8'h91 -> a_gnt then a_err; cmdvalid never asserted.
5. Timeout: TIMEOUT_CYC=100, no done -> a_err exactly 100 cycles after cmdvalid. eeprom_wr_done held high from an earlier write plus an eeprom_rd_done edge during a write wait -> neither completes the write.
6. rst_n low during WAIT -> all outputs 0 immediately. After release, a held a_req is re-granted and completes normally.
